// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/sequencing stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  localparam logic [5:0]  OP_RTYPE  = 6'd0;
  localparam logic [5:0]  OP_J      = 6'd2;
  localparam logic [5:0]  OP_BEQ    = 6'd4;
  localparam logic [5:0]  OP_BNE    = 6'd5;
  localparam logic [5:0]  OP_LW     = 6'd35;
  localparam logic [5:0]  OP_SW     = 6'd43;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Sequential / jump / branch target of the instruction held at pc.
  function automatic logic [31:0] calc_next_pc(input logic [31:0] pc,
                                               input logic [31:0] instr,
                                               input logic        eq);
    logic [31:0] pc4;
    logic [5:0]  op;
    pc4 = pc + 32'd4;
    op  = instr[31:26];
    if (op == OP_J)
      return {pc4[31:28], instr[25:0], 2'b00};
    if ((op == OP_BEQ && eq) || (op == OP_BNE && !eq))
      return pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    return pc4;
  endfunction

endpackage

// File: rtl/instr_rom.sv
// Instruction memory: synchronous write, asynchronous read, contents never reset.
module instr_rom #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Program load port
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/sequencing stage: holds PC, presents one instruction per slot,
// resolves j/beq/bne at slot end, halts on halt word or out-of-range PC.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int IMEM_DEPTH  = 128,
  parameter int SLOT_CYCLES = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic                          regs_equal,
  output logic [31:0]                   instrword,
  output logic                          newinstr,
  output logic [31:0]                   pc,
  output logic                          halted,
  output logic                          busy
);

  localparam int          AW       = $clog2(IMEM_DEPTH);
  localparam int          CW       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

  fetch_state_t  state, state_n;
  logic [31:0]   pc_n, instr_n, rd_data, npc;
  logic          newinstr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          idle_like;

  assign idle_like = (state == S_IDLE) || (state == S_HALT);

  // Writes are only accepted while nothing is executing
  instr_rom #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_rom (
    .clock (clock),
    .we    (prog_we && idle_like),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc[AW+1:2]),
    .rdata (rd_data)
  );

  assign npc    = calc_next_pc(pc, instrword, regs_equal);
  assign halted = (state == S_HALT);
  assign busy   = (state == S_FETCH) || (state == S_HOLD);

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      instrword <= '0;
      newinstr  <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      instrword <= instr_n;
      newinstr  <= newinstr_n;
      cnt       <= cnt_n;
    end
  end

  // Next-state, slot counter and PC selection
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instrword;
    newinstr_n = 1'b0;
    cnt_n      = cnt;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_n = S_FETCH;
          pc_n    = '0;
        end
      end
      S_FETCH: begin
        instr_n    = rd_data;
        newinstr_n = 1'b1;
        cnt_n      = CW'(SLOT_CYCLES - 1);
        state_n    = S_HOLD;
      end
      S_HOLD: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (instrword == HALT_WORD || npc >= PC_LIMIT) begin
          // pc stays on the offending instruction for inspection
          state_n = S_HALT;
        end else begin
          pc_n    = npc;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: directed programs plus random programs against a
// behavioural per-instruction model of the fetch sequencer.
module tb_instr_fetch_unit;

  localparam int DEPTH = 128;
  localparam int SLOT  = 4;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [6:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        regs_equal = 1'b0;
  logic [31:0] instrword, pc;
  logic        newinstr, halted, busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [DEPTH];

  instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .SLOT_CYCLES(SLOT)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .regs_equal (regs_equal),
    .instrword  (instrword),
    .newinstr   (newinstr),
    .pc         (pc),
    .halted     (halted),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = 7'(a);
    prog_data = d;
    mem[a]    = d;
    @(negedge clock);
    prog_we   = 1'b0;
  endtask

  // Model of one slot's outcome, straight from the sequencing rules
  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] w, input bit eq);
    int unsigned op;
    int          off;
    logic [31:0] p4;
    op = w >> 26;
    p4 = p + 32'd4;
    if (op == 2) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    if ((op == 4 && eq) || (op == 5 && !eq)) begin
      off = int'(w & 32'hFFFF);
      if (off >= 32768) off -= 65536;
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  // Start a run and follow it instruction by instruction.
  // eq_mode: -1 random regs_equal, else fixed. poke: drive prog_we/start mid-HOLD.
  task automatic run_prog(input int max_instr, input int eq_mode, input bit poke,
                          output bit did_halt);
    logic [31:0] pc_m, w, npc;
    bit          eq, hlt, extra_pulse;
    int          gap;
    did_halt = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_fetch", 32'(busy), 32'd1);
    gap = 0;
    while (!newinstr && gap < 10) begin
      @(negedge clock);
      gap++;
    end
    chk("first_latency", gap, 1);
    if (!newinstr) return;
    pc_m = 0;
    for (int n = 0; n < max_instr; n++) begin
      w = mem[pc_m[8:2]];
      chk("pc", pc, pc_m);
      chk("instrword", instrword, w);
      chk("busy_hold", 32'(busy), 32'd1);
      eq = (eq_mode < 0) ? bit'($urandom_range(0, 1)) : bit'(eq_mode);
      regs_equal = eq;
      npc = model_npc(pc_m, w, eq);
      hlt = (w == HALTW) || (npc >= 32'(4 * DEPTH));
      if (n == max_instr - 1 && !hlt) begin
        // abandon the slot with an asynchronous reset between edges
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_instr", instrword, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_flags", {29'd0, newinstr, halted, busy}, 32'd0);
        #1 reset = 1'b0;
        @(negedge clock);
        return;
      end
      extra_pulse = 1'b0;
      for (int k = 1; k <= SLOT; k++) begin
        @(negedge clock);
        if (newinstr) extra_pulse = 1'b1;
        if (poke && n == 0 && k == 2) begin
          prog_we = 1'b1; prog_addr = 7'd0; prog_data = ~mem[0]; start = 1'b1;
        end
        if (poke && n == 0 && k == 3) begin
          prog_we = 1'b0; start = 1'b0;
        end
      end
      chk("newinstr_single", 32'(extra_pulse), 32'd0);
      if (hlt) begin
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", pc, pc_m);
        chk("halt_instr", instrword, w);
        chk("halt_busy", 32'(busy), 32'd0);
        did_halt = 1'b1;
        return;
      end
      chk("pc_early", pc, npc);
      chk("instr_stable", instrword, w);
      @(negedge clock);
      chk("newinstr_period", 32'(newinstr), 32'd1);
      if (!newinstr) return;
      pc_m = npc;
    end
  endtask

  function automatic logic [31:0] rand_word();
    int unsigned sel;
    logic [31:0] r;
    sel = $urandom_range(0, 9);
    r   = $urandom;
    case (sel)
      0, 1: return {6'd0, r[25:0]};
      2:    return {6'd35, r[25:0]};
      3:    return {6'd43, r[25:0]};
      4:    return {6'd4, r[25:16], 16'($signed($urandom_range(0, 8)) - 4)};
      5:    return {6'd5, r[25:16], 16'($signed($urandom_range(0, 8)) - 4)};
      6:    return {6'd2, 26'($urandom_range(0, 140))};
      7:    return (r[3:0] == 4'd0) ? HALTW : {6'd0, r[25:0]};
      default: return {6'd0, r[25:0]};
    endcase
  endfunction

  bit hd;

  initial begin
    reset = 1'b1;
    #1;
    chk("reset_pc", pc, 32'd0);
    chk("reset_instr", instrword, 32'd0);
    chk("reset_flags", {29'd0, newinstr, halted, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) load(i, 32'd0);

    // Sequential fetch
    load(0, 32'h012A4020); load(1, 32'h8D090004); load(2, HALTW);
    run_prog(10, 0, 1'b0, hd);
    chk("seq_halted", 32'(hd), 32'd1);

    // beq taken / not taken
    load(0, 32'h11090002); load(1, HALTW); load(3, HALTW);
    run_prog(5, 1, 1'b0, hd);
    chk("beq_t_end", pc, 32'd12);
    run_prog(5, 0, 1'b0, hd);
    chk("beq_nt_end", pc, 32'd4);

    // bne backward from pc 12
    load(0, 32'h08000003); load(3, 32'h1509FFFD);
    run_prog(5, 0, 1'b0, hd);
    chk("bne_end", pc, 32'd4);

    // jump
    load(0, 32'h08000005); load(5, HALTW);
    run_prog(5, 0, 1'b0, hd);
    chk("jump_end", pc, 32'd20);

    // out-of-range jump to word 200
    load(0, 32'h080000C8);
    run_prog(5, 0, 1'b0, hd);
    chk("oor_halted", 32'(hd), 32'd1);

    // write/start during HOLD ignored, then reset mid-slot, memory retained
    load(0, 32'h012A4020); load(1, 32'h8D090004); load(2, HALTW);
    run_prog(10, 0, 1'b1, hd);
    run_prog(2, 0, 1'b0, hd);
    run_prog(10, 0, 1'b0, hd);
    chk("guard_mem", 32'(hd), 32'd1);

    // Random programs
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < DEPTH; i++) load(i, rand_word());
      run_prog(40, -1, 1'b0, hd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and sequencing stage directly upstream of the `mipscpu` datapath. It holds the PC and a loadable instruction memory, and presents one instruction word at a time on `instrword` with a one-cycle `newinstr` pulse. The word is held stable for a fixed multi-cycle execution slot so the datapath's control FSM can complete R-type, `lw` and `sw` sequences. At the end of each slot it resolves `j`, `beq` and `bne` to select the next PC, and it halts on a halt word or an out-of-range fetch.

## Interface
- `IMEM_DEPTH`, 128: instruction memory depth in words; must be a power of two.
- `SLOT_CYCLES`, 4: HOLD cycles per instruction; must be ≥ 1.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high. Clears PC, state and outputs; memory contents are retained.
- `start` in 1: begin execution from PC 0. Honoured only in IDLE or HALT.
- `prog_we` in 1: instruction memory write enable. Honoured only in IDLE or HALT.
- `prog_addr` in log2(IMEM_DEPTH): word address for the write.
- `prog_data` in 32: word to write.
- `regs_equal` in 1: datapath rs==rt comparison. Sampled on the last HOLD cycle.
- `instrword` out 32: current instruction, registered.
- `newinstr` out 1: one-cycle pulse in the first cycle a new `instrword` is valid.
- `pc` out 32: byte address of the current instruction.
- `halted` out 1: high while in HALT.
- `busy` out 1: high in FETCH or HOLD.

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- Reset values: state=IDLE, `pc`=0, `instrword`=0, `newinstr`=0, `halted`=0, `busy`=0, slot counter=0.
- IDLE:
  - `prog_we` writes `prog_data` to mem[`prog_addr`] at the edge.
  - `start` → FETCH with `pc`=0.
  - If `prog_we` and `start` are both high, the write completes and execution starts on the same edge.
- FETCH (one cycle), at the edge:
  - `instrword` ← mem[`pc`[log2(IMEM_DEPTH)+1:2]]
  - `newinstr` ← 1
  - counter ← SLOT_CYCLES−1
  - → HOLD
- HOLD:
  - `newinstr` ← 0.
  - If counter≠0: decrement the counter.
  - If counter==0: compute next PC, then → FETCH, or → HALT.
- Next-PC rules (pc4 = `pc`+4; 32-bit wrap-around arithmetic):
  - opcode 2 (`j`): {pc4[31:28], `instrword`[25:0], 2'b00}
  - opcode 4 (`beq`) with `regs_equal`=1, or opcode 5 (`bne`) with `regs_equal`=0: pc4 + (sign-extended `instrword`[15:0] << 2)
  - otherwise: pc4
- HALT conditions, checked on the last HOLD cycle:
  - `instrword`==32'hFFFF_FFFF: → HALT, `pc` unchanged.
  - Next PC ≥ 4·IMEM_DEPTH: → HALT, `pc` unchanged.
  - In both cases `halted` is set.
- HALT: `instrword` holds its value, `newinstr`=0, `prog_we` honoured, `start` restarts from `pc`=0 and clears `halted`.
- `start` in FETCH or HOLD is ignored; `prog_we` in FETCH or HOLD is ignored with no write.
- Reset asserted mid-slot: immediate return to IDLE with all outputs at reset values; the held instruction is abandoned.

## Timing
- `start` sampled at edge E0 → FETCH during E0..E1 → `instrword` and `newinstr` valid after E1.
- Instruction period: SLOT_CYCLES+1 clocks (5 by default). `instrword` is stable for the whole period.
- `newinstr` is high for exactly one cycle per instruction, coincident with the first cycle of the new word.
- `pc` changes at the same edge that leaves HOLD, one cycle before the new `instrword`.
- `regs_equal` must be valid in the cycle where counter==0; it is not sampled in any other cycle.
- Memory read is combinational from `pc` and registered into `instrword`. A write to the current fetch address in IDLE is visible to the next fetch.

## Structure
- Shared package `fetch_pkg`:
  - state enum
  - opcode constants OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_BNE=5, OP_LW=35, OP_SW=43
  - HALT_WORD=32'hFFFF_FFFF
- Sub-module `instr_rom`: IMEM_DEPTH×32 array with a synchronous write port and an asynchronous read port. No reset of its contents.
- The top level holds the FSM, slot counter, PC and next-PC adder.

## Test plan
- Sequential fetch:
  - Stimulus: load words 0x012A4020, 0x8D090004, HALT_WORD; then `start`.
  - Response: `instrword` sequence matches; `pc` is 0, 4, 8; `newinstr` pulses exactly 5 clocks apart; `halted`=1 with `pc`=8.
- `beq` taken:
  - Stimulus: mem[0]=0x11090002, `regs_equal`=1.
  - Response: next `pc`=12.
  - Repeat with `regs_equal`=0: next `pc`=4.
- `bne` backward:
  - Stimulus: mem[3]=0x1509FFFD at `pc`=12, `regs_equal`=0.
  - Response: next `pc`=4.
- Jump:
  - Stimulus: mem[0]=0x08000005.
  - Response: next `pc`=20, `instrword`=mem[5].
- Out-of-range:
  - Stimulus: `j` to word 200 with IMEM_DEPTH=128.
  - Response: → HALT, `halted`=1, `pc` unchanged.
- Guarding and reset:
  - Stimulus: `prog_we` during HOLD; then `reset` asserted mid-HOLD between edges.
  - Response: the write is ignored. Outputs go to 0 asynchronously and IDLE is entered. After a later `start`, memory contents are intact.
